// File: rtl/multiword_add_seq.sv
// multiword_add_seq: adds two WORDS x 16-bit operands one chunk per cycle, LSB chunk first,
// through a single ripple_carry_adder_16 with the chunk carry registered between cycles.
module ripple_carry_adder_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [16:0] c;
    assign c[0] = cin;
    genvar i;
    generate
        for (i = 0; i < 16; i++) begin : g_fa
            assign sum[i]   = a[i] ^ b[i] ^ c[i];
            assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    endgenerate
    assign cout = c[16];
endmodule

module multiword_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [16*WORDS-1:0] a,
    input  logic [16*WORDS-1:0] b,
    input  logic                cin,
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic [16*WORDS-1:0] sum,
    output logic                cout,
    output logic                overflow
);
    localparam int W  = 16 * WORDS;
    localparam int IW = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, work_q, work_d, sum_q, sum_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [15:0]     add_s;
    logic            add_c, last;

    ripple_carry_adder_16 u_add (
        .a    (a_q[16*idx_q +: 16]),
        .b    (b_q[16*idx_q +: 16]),
        .cin  (carry_q),
        .sum  (add_s),
        .cout (add_c)
    );

    assign last     = idx_q == IW'(WORDS - 1);
    assign ready    = state_q != ADD;
    assign busy     = state_q == ADD;
    assign done     = state_q == DONE;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (state_q != ADD && start) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            idx_d   = '0;
            state_d = ADD;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end else if (state_q == ADD) begin
            work_d[16*idx_q +: 16] = add_s;
            carry_d = add_c;
            idx_d   = last ? idx_q : idx_q + IW'(1);
            if (last) begin
                // the final chunk comes straight from the adder, not from work_q
                state_d = DONE;
                sum_d   = work_d;
                cout_d  = add_c;
                ovf_d   = (a_q[W-1] == b_q[W-1]) && (work_d[W-1] != a_q[W-1]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule
